// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86 fetch constants
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] REG_NONE = 4'hF;

endpackage

// File: rtl/y86_instr_len.sv
// rtl/y86_instr_len.sv - icode to instruction length and field-presence flags
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [2:0] len,
    output logic       has_reg,
    output logic       has_valc
);

    // Invalid icodes fall to the 1-byte default; the fetch FSM traps them first
    always_comb begin
        len      = 3'd1;
        has_reg  = 1'b0;
        has_valc = 1'b0;
        case (icode)
            I_RRMOV, I_OP, I_PUSH, I_POP: begin
                len     = 3'd2;
                has_reg = 1'b1;
            end
            I_IRMOV, I_RMMOV, I_MRMOV: begin
                len      = 3'd6;
                has_reg  = 1'b1;
                has_valc = 1'b1;
            end
            I_JXX, I_CALL: begin
                len      = 3'd5;
                has_valc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/y86_fetch.sv
// rtl/y86_fetch.sv - Y86 PC register and byte-serial fetch sequencer
module y86_fetch
    import y86_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [ADDR_W-1:0] valC,
    output logic [ADDR_W-1:0] valP,
    output logic [ADDR_W-1:0] pc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [1:0]        stat
);

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_VALID = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    logic [2:0]        state;
    logic [2:0]        cnt;
    logic [3:0]        len_icode;
    logic [2:0]        len;
    logic              has_reg;
    logic              has_valc;
    logic              last_byte;
    logic [2:0]        valc_idx;
    logic [ADDR_W-1:0] byte_ext;
    logic [ADDR_W-1:0] cnt_ext;
    logic [ADDR_W-1:0] len_ext;

    // On byte 0 the length comes straight from the arriving byte, later from the latched icode
    assign len_icode = (cnt == 3'd0) ? mem_rdata[7:4] : icode;

    y86_instr_len u_len (
        .icode    (len_icode),
        .len      (len),
        .has_reg  (has_reg),
        .has_valc (has_valc)
    );

    assign last_byte = (cnt == len - 3'd1);
    // valC starts after the register byte when there is one
    assign valc_idx  = has_reg ? cnt - 3'd2 : cnt - 3'd1;
    assign byte_ext  = {{(ADDR_W-8){1'b0}}, mem_rdata};
    assign cnt_ext   = {{(ADDR_W-3){1'b0}}, cnt};
    assign len_ext   = {{(ADDR_W-3){1'b0}}, len};

    // Request is gated by reset so it is low while reset is held and high the first cycle after
    assign mem_req   = (state == ST_FETCH) && rst_n;
    assign mem_addr  = pc + cnt_ext;
    assign out_valid = (state == ST_VALID);

    // Fetch FSM, byte assembly and PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            cnt   <= 3'd0;
            pc    <= RESET_PC;
            icode <= I_HALT;
            ifun  <= 4'h0;
            rA    <= REG_NONE;
            rB    <= REG_NONE;
            valC  <= '0;
            valP  <= '0;
            stat  <= STAT_AOK;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ack) begin
                        if (mem_err) begin
                            stat  <= STAT_ADR;
                            state <= ST_ERR;
                        end else if (cnt == 3'd0 && mem_rdata[7:4] > I_POP) begin
                            stat  <= STAT_INS;
                            state <= ST_ERR;
                        end else begin
                            if (cnt == 3'd0) begin
                                icode <= mem_rdata[7:4];
                                ifun  <= mem_rdata[3:0];
                                rA    <= REG_NONE;
                                rB    <= REG_NONE;
                                valC  <= '0;
                            end else if (has_reg && cnt == 3'd1) begin
                                rA <= mem_rdata[7:4];
                                rB <= mem_rdata[3:0];
                            end else if (has_valc) begin
                                valC <= valC | (byte_ext << {valc_idx, 3'b000});
                            end
                            if (last_byte) begin
                                valP  <= pc + len_ext;
                                cnt   <= 3'd0;
                                state <= ST_VALID;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                end
                ST_VALID: begin
                    if (out_ready) begin
                        if (icode == I_HALT) begin
                            stat  <= STAT_HLT;
                            state <= ST_HALT;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (pc_load) begin
                        pc    <= pc_in;
                        cnt   <= 3'd0;
                        state <= ST_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_fetch.sv
// tb/tb_y86_fetch.sv - scoreboard testbench for y86_fetch
module tb_y86_fetch;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] valc;
        logic [31:0] valp;
        logic [1:0]  stat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_err;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [31:0] valC;
    logic [31:0] valP;
    logic [31:0] pc;
    logic        pc_load;
    logic [31:0] pc_in;
    logic [1:0]  stat;

    logic [7:0]  mem [0:511];
    logic [31:0] addr_log [$];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          valid_cnt = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic [31:0] held_addr = '0;

    y86_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .valC      (valC),
        .valP      (valP),
        .pc        (pc),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .stat      (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                            input logic [3:0] rb, input logic [31:0] vc, input logic [31:0] vp);
        exp_t e;
        e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.stat = 2'd0;
        sb.push_back(e);
    endtask

    // Memory responder: ack after ack_delay idle cycles, one byte per ack
    always @(negedge clk) begin
        if (rst_n && mem_req) begin
            if (wait_cnt == 0) held_addr = mem_addr;
            else check("addr_hold", mem_addr, held_addr);
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[8:0]];
                mem_err   = err_en && (mem_addr == err_addr);
                addr_log.push_back(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ack  = 1'b0;
                mem_err  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            mem_ack  = 1'b0;
            mem_err  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Scoreboard: compare on each accepted output
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            valid_cnt++;
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_icode", {28'd0, icode}, {28'd0, e.icode});
                    check("sb_ifun",  {28'd0, ifun},  {28'd0, e.ifun});
                    check("sb_rA",    {28'd0, rA},    {28'd0, e.ra});
                    check("sb_rB",    {28'd0, rB},    {28'd0, e.rb});
                    check("sb_valC",  valC, e.valc);
                    check("sb_valP",  valP, e.valp);
                    check("sb_stat",  {30'd0, stat}, {30'd0, e.stat});
                end
            end
        end
    end

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (out_valid) break;
            @(posedge clk); #1;
        end
        check(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_stat(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (stat != 2'd0) break;
            @(posedge clk); #1;
        end
        check(tag, {31'd0, stat != 2'd0}, 32'd1);
    endtask

    task automatic accept_and_load(input logic [31:0] addr);
        @(posedge clk); #1;
        addr_log.delete();
        pc_in   = addr;
        pc_load = 1'b1;
        @(posedge clk); #1;
        pc_load = 1'b0;
        check("load_pc", pc, addr);
        check("load_req", {31'd0, mem_req}, 32'd1);
        check("load_addr", mem_addr, addr);
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; pc_load = 1'b0; pc_in = '0;
        mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0] = 8'h10;
        {mem[16], mem[17], mem[18], mem[19], mem[20], mem[21]} = 48'h30F3_7856_3412;
        {mem[32], mem[33], mem[34], mem[35], mem[36]} = 40'h80_0001_0000;
        mem[256] = 8'hC0;

        // Reset state
        repeat (2) @(posedge clk); #1;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_icode", {28'd0, icode}, 32'd0);
        check("rst_rA", {28'd0, rA}, 32'hF);
        check("rst_rB", {28'd0, rB}, 32'hF);
        check("rst_valC", valC, 32'h0);
        check("rst_valP", valP, 32'h0);
        check("rst_stat", {30'd0, stat}, 32'd0);

        // nop at 0, zero-wait memory
        push_exp(4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h1);
        rst_n = 1'b1; #1;
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0);
        check("first_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("nop_latency", {31'd0, out_valid}, 32'd1);

        // irmovl at 0x10, one wait cycle per byte
        ack_delay = 1;
        push_exp(4'h3, 4'h0, 4'hF, 4'h3, 32'h1234_5678, 32'h16);
        accept_and_load(32'h10);
        wait_valid("irmov_valid", 40);
        check("irmov_nbytes", addr_log.size(), 32'd6);
        for (int i = 0; i < 6 && i < addr_log.size(); i++)
            check("irmov_addr", addr_log[i], 32'h10 + i);

        // call at 0x20 with decode stalled; pc_load ignored while valid
        push_exp(4'h8, 4'h0, 4'hF, 4'hF, 32'h100, 32'h25);
        accept_and_load(32'h20);
        out_ready = 1'b0;
        wait_valid("call_valid", 40);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_icode", {28'd0, icode}, 32'd8);
            check("stall_valC", valC, 32'h100);
            check("stall_valP", valP, 32'h25);
            pc_in = 32'h300; pc_load = 1'b1;
            @(posedge clk); #1;
        end
        pc_load = 1'b0;
        check("stall_pc", pc, 32'h20);
        out_ready = 1'b1; pc_load = 1'b1;
        @(posedge clk); #1;
        pc_load = 1'b0;
        check("accept_load_ignored", pc, 32'h20);
        check("wait_req", {31'd0, mem_req}, 32'd0);
        check("wait_valid", {31'd0, out_valid}, 32'd0);
        accept_and_load(32'h100);

        // Invalid icode C at 0x100
        wait_stat("ins_stat_wait", 20);
        check("ins_stat", {30'd0, stat}, 32'd3);
        check("ins_req", {31'd0, mem_req}, 32'd0);
        pc_in = 32'h40; pc_load = 1'b1;
        @(posedge clk); #1;
        pc_load = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("ins_pc_held", pc, 32'h100);
        check("ins_req_held", {31'd0, mem_req}, 32'd0);
        check("ins_stat_held", {30'd0, stat}, 32'd3);

        // jXX at 0 with address error on byte 3
        {mem[0], mem[1], mem[2], mem[3], mem[4]} = 40'h70_0002_0000;
        err_en = 1'b1; err_addr = 32'h3; ack_delay = 0;
        rst_n = 1'b0; #1;
        check("rst_abort_pc", pc, 32'h0);
        check("rst_abort_stat", {30'd0, stat}, 32'd0);
        @(posedge clk); #1;
        begin
            int vc0;
            vc0 = valid_cnt;
            rst_n = 1'b1;
            wait_stat("adr_stat_wait", 20);
            check("adr_stat", {30'd0, stat}, 32'd2);
            check("adr_req", {31'd0, mem_req}, 32'd0);
            repeat (3) @(posedge clk); #1;
            check("adr_no_valid", valid_cnt - vc0, 32'd0);
        end

        // 6-byte fetch interrupted by reset, then refetched; then halt
        err_en = 1'b0; ack_delay = 1;
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = 48'h30F3_7856_3412;
        mem[80] = 8'h00;
        rst_n = 1'b0;
        @(posedge clk); #1;
        addr_log.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (addr_log.size() >= 3) break;
            @(posedge clk); #1;
        end
        check("mid_progress", {31'd0, addr_log.size() >= 3}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        addr_log.delete();
        push_exp(4'h3, 4'h0, 4'hF, 4'h3, 32'h1234_5678, 32'h6);
        rst_n = 1'b1;
        wait_valid("refetch_valid", 40);
        check("refetch_nbytes", addr_log.size(), 32'd6);
        if (addr_log.size() > 0) check("refetch_first", addr_log[0], 32'h0);
        push_exp(4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h51);
        accept_and_load(32'h50);
        wait_valid("halt_valid", 20);
        @(posedge clk); #1;
        check("halt_stat", {30'd0, stat}, 32'd1);
        check("halt_valid_drop", {31'd0, out_valid}, 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            check("halt_no_req", {31'd0, mem_req}, 32'd0);
        end

        check("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
